ps2_word_packer: RTL and testbench

//  Transmit side of the rsa 128-bit valid/ready input port.
//  - Collects PS/2 scan bytes (ps2_data_i/ps2_valid_i) into WORD_W-bit words.
//  - Presents each word on rsa_data_o/rsa_valid_o, held until rsa_ready_i.
//  - Sits between the PS/2 byte receiver and rsa; ps2_done flushes a partial word, ps2_reset clears state.

---
 rtl/ps2_pack_pkg.sv | 19 +
 rtl/pack_out_reg.sv | 79 +++++++
 rtl/ps2_word_packer.sv | 122 ++++++++++++
 tb/tb_ps2_word_packer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pack_pkg.sv
// Shared constants and types for the PS/2 -> rsa word packer.
//   WORD_W : width of one packed output word
//   BYTE_W : width of one PS/2 scan byte
//   NBYTES : bytes per word (derived)
//   IDX_W  : width of a byte index / byte count (0..NBYTES)
//   acc_state_t : accumulator FSM states (FILL, PEND)
package ps2_pack_pkg;

    localparam int unsigned WORD_W = 128;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned NBYTES = WORD_W / BYTE_W;
    localparam int unsigned IDX_W  = $clog2(NBYTES + 1);

    typedef enum logic {
        FILL = 1'b0,
        PEND = 1'b1
    } acc_state_t;

endpackage

// File: rtl/pack_out_reg.sv
// Valid/ready holding register for packed words.
// Ports:
//   clk, rst  : clock (rising edge), asynchronous active-low reset
//   load_i    : capture data_i (and len_i) as a new word this edge
//   data_i    : word to capture
//   len_i     : byte count of the word (only with PS2_PACK_LEN_EN)
//   ready_i   : sink ready; a transfer happens when valid_o && ready_i
//   valid_o   : word held and valid
//   data_o    : held word, stable while valid_o && !ready_i
//   len_o     : held byte count (only with PS2_PACK_LEN_EN)
//   free_o    : register can accept a new word this edge
// Optional feature macro: PS2_PACK_LEN_EN.
module pack_out_reg
    import ps2_pack_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [WORD_W-1:0] data_i,
`ifdef PS2_PACK_LEN_EN
    input  logic [IDX_W-1:0]  len_i,
    output logic [IDX_W-1:0]  len_o,
`endif
    input  logic              ready_i,
    output logic              valid_o,
    output logic [WORD_W-1:0] data_o,
    output logic              free_o
);

    logic              valid_q, valid_d;
    logic [WORD_W-1:0] data_q,  data_d;
`ifdef PS2_PACK_LEN_EN
    logic [IDX_W-1:0]  len_q,   len_d;
`endif

    // Empty, or the held word leaves on this edge.
    assign free_o = !valid_q || ready_i;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
`ifdef PS2_PACK_LEN_EN
        len_d   = len_q;
`endif
        if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
`ifdef PS2_PACK_LEN_EN
            len_d   = len_i;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
`ifdef PS2_PACK_LEN_EN
            len_q   <= '0;
`endif
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
`ifdef PS2_PACK_LEN_EN
            len_q   <= len_d;
`endif
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
`ifdef PS2_PACK_LEN_EN
    assign len_o   = len_q;
`endif

endmodule

// File: rtl/ps2_word_packer.sv
// Packs PS/2 scan bytes into WORD_W-bit words for the rsa valid/ready input.
// Ports:
//   clk, rst     : clock (rising edge), asynchronous active-low reset
//   ps2_data_i   : received byte
//   ps2_valid_i  : one-cycle byte strobe (no backpressure)
//   ps2_done     : end of message, flushes a partial word
//   ps2_reset    : synchronous clear of packing state and overflow flag
//   rsa_data_o   : packed word, first byte in the LSBs, unfilled bytes 0
//   rsa_valid_o  : word valid, held until rsa_ready_i
//   rsa_ready_i  : sink ready
//   rsa_len_o    : valid byte count of rsa_data_o (only with PS2_PACK_LEN_EN)
//   overflow_o   : sticky, a byte was dropped
// Optional feature macro: PS2_PACK_LEN_EN.
module ps2_word_packer
    import ps2_pack_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [BYTE_W-1:0] ps2_data_i,
    input  logic              ps2_valid_i,
    input  logic              ps2_done,
    input  logic              ps2_reset,
    output logic [WORD_W-1:0] rsa_data_o,
    output logic              rsa_valid_o,
    input  logic              rsa_ready_i,
`ifdef PS2_PACK_LEN_EN
    output logic [IDX_W-1:0]  rsa_len_o,
`endif
    output logic              overflow_o
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    acc_state_t        state_q, state_d;
    logic [WORD_W-1:0] acc_q,   acc_d;
    logic [IDX_W-1:0]  cnt_q,   cnt_d;
    logic              ovf_q,   ovf_d;
    logic              load;
    logic              out_free;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        load    = 1'b0;

        if (ps2_reset) begin
            state_d = FILL;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                FILL: begin
                    if (ps2_valid_i) begin
                        for (int unsigned k = 0; k < NBYTES; k++) begin
                            if (cnt_q == IDX_W'(k)) begin
                                acc_d[k*BYTE_W +: BYTE_W] = ps2_data_i;
                            end
                        end
                        cnt_d = cnt_q + IDX_W'(1);
                        if (cnt_q == LAST_IDX || ps2_done) begin
                            state_d = PEND;
                        end
                    end else if (ps2_done && cnt_q != '0) begin
                        state_d = PEND;
                    end
                end
                PEND: begin
                    if (out_free) begin
                        load    = 1'b1;
                        state_d = FILL;
                        acc_d   = '0;
                        cnt_d   = '0;
                        // A byte on the move edge starts the next word; any
                        // ps2_done with it is ignored like other done in PEND.
                        if (ps2_valid_i) begin
                            acc_d[BYTE_W-1:0] = ps2_data_i;
                            cnt_d             = IDX_W'(1);
                        end
                    end else if (ps2_valid_i) begin
                        ovf_d = 1'b1;
                    end
                end
                default: state_d = FILL;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= FILL;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    pack_out_reg u_out (
        .clk     (clk),
        .rst     (rst),
        .load_i  (load),
        .data_i  (acc_q),
`ifdef PS2_PACK_LEN_EN
        .len_i   (cnt_q),
        .len_o   (rsa_len_o),
`endif
        .ready_i (rsa_ready_i),
        .valid_o (rsa_valid_o),
        .data_o  (rsa_data_o),
        .free_o  (out_free)
    );

    assign overflow_o = ovf_q;

endmodule

// File: tb/tb_ps2_word_packer.sv
module tb_ps2_word_packer;
    import ps2_pack_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic [BYTE_W-1:0] ps2_data_i;
    logic              ps2_valid_i;
    logic              ps2_done;
    logic              ps2_reset;
    logic [WORD_W-1:0] rsa_data_o;
    logic              rsa_valid_o;
    logic              rsa_ready_i;
    logic              overflow_o;
`ifdef PS2_PACK_LEN_EN
    logic [IDX_W-1:0]  rsa_len_o;
`endif

    typedef struct {
        logic [WORD_W-1:0] data;
        logic [IDX_W-1:0]  len;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    ps2_word_packer dut (
        .clk         (clk),
        .rst         (rst),
        .ps2_data_i  (ps2_data_i),
        .ps2_valid_i (ps2_valid_i),
        .ps2_done    (ps2_done),
        .ps2_reset   (ps2_reset),
        .rsa_data_o  (rsa_data_o),
        .rsa_valid_o (rsa_valid_o),
        .rsa_ready_i (rsa_ready_i),
`ifdef PS2_PACK_LEN_EN
        .rsa_len_o   (rsa_len_o),
`endif
        .overflow_o  (overflow_o)
    );

    task automatic check(input string name, input logic [WORD_W-1:0] act,
                         input logic [WORD_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [WORD_W-1:0] mk(input int unsigned start, input int unsigned n);
        logic [WORD_W-1:0] w;
        w = '0;
        for (int unsigned k = 0; k < n; k++) begin
            w[k*BYTE_W +: BYTE_W] = BYTE_W'(start + k);
        end
        return w;
    endfunction

    task automatic push(input logic [WORD_W-1:0] d, input int unsigned n);
        exp_t e;
        e.data = d;
        e.len  = IDX_W'(n);
        sb.push_back(e);
    endtask

    // Inputs change 1ns after a rising edge.
    task automatic send_byte(input logic [BYTE_W-1:0] b, input logic with_done);
        ps2_data_i  = b;
        ps2_valid_i = 1'b1;
        ps2_done    = with_done;
        @(posedge clk);
        #1;
        ps2_valid_i = 1'b0;
        ps2_done    = 1'b0;
        ps2_data_i  = '0;
    endtask

    task automatic send_run(input int unsigned start, input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            send_byte(BYTE_W'(start + i), 1'b0);
        end
    endtask

    task automatic pulse_done();
        ps2_done = 1'b1;
        @(posedge clk);
        #1;
        ps2_done = 1'b0;
    endtask

    task automatic pulse_reset();
        ps2_reset = 1'b1;
        @(posedge clk);
        #1;
        ps2_reset = 1'b0;
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: pops on each transfer, checks hold stability against the
    // scoreboard head while the sink stalls.
    initial begin
        forever begin
            @(negedge clk);
            if (rst && rsa_valid_o) begin
                if (sb.size() == 0) begin
                    check("unexpected_word", {{(WORD_W-1){1'b0}}, rsa_valid_o}, '0);
                end else begin
                    check("word_data", rsa_data_o, sb[0].data);
`ifdef PS2_PACK_LEN_EN
                    check("word_len", {{(WORD_W-IDX_W){1'b0}}, rsa_len_o},
                          {{(WORD_W-IDX_W){1'b0}}, sb[0].len});
`endif
                    if (rsa_ready_i) begin
                        void'(sb.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b0;
        ps2_data_i  = '0;
        ps2_valid_i = 1'b0;
        ps2_done    = 1'b0;
        ps2_reset   = 1'b0;
        rsa_ready_i = 1'b1;
        #2;
        check("reset_valid", rsa_valid_o, '0);
        check("reset_data", rsa_data_o, '0);
        check("reset_ovf", overflow_o, '0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        idle(2);

        // 1: full word, latency 2 edges after last byte, valid one cycle
        push(128'h0F0E0D0C0B0A09080706050403020100, 16);
        send_run(8'h00, 16);
        @(negedge clk);
        check("t1_valid_e0", rsa_valid_o, '0);
        @(negedge clk);
        check("t1_valid_e1", rsa_valid_o, 1);
        @(negedge clk);
        check("t1_valid_e2", rsa_valid_o, '0);
        @(posedge clk);
        #1;
        idle(2);

        // 2: partial word flushed by ps2_done
        push(128'h0000000000000000000000000000_00CCBBAA, 3);
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        send_byte(8'hCC, 1'b0);
        pulse_done();
        idle(4);
        check("t2_sb_empty", WORD_W'(sb.size()), '0);

        // 3: stalled sink, second word fills, 33rd byte dropped
        rsa_ready_i = 1'b0;
        push(mk(8'h00, 16), 16);
        push(mk(8'h10, 16), 16);
        send_run(8'h00, 33);
        check("t3_ovf", overflow_o, 1);
        check("t3_valid_held", rsa_valid_o, 1);
        idle(3);
        check("t3_data_held", rsa_data_o, mk(8'h00, 16));
        rsa_ready_i = 1'b1;
        idle(4);
        check("t3_sb_empty", WORD_W'(sb.size()), '0);
        check("t3_ovf_sticky", overflow_o, 1);

        // 4: done on empty word emits nothing; byte+done emits one-byte word
        pulse_done();
        repeat (4) begin
            @(negedge clk);
            check("t4_no_empty_word", rsa_valid_o, '0);
        end
        @(posedge clk);
        #1;
        push(128'h55, 1);
        send_byte(8'h55, 1'b1);
        idle(4);
        check("t4_sb_empty", WORD_W'(sb.size()), '0);

        // 5: ps2_reset discards partial word and clears overflow
        send_run(8'h01, 5);
        pulse_reset();
        check("t5_ovf_cleared", overflow_o, '0);
        push(128'h0F0E0D0C0B0A09080706050403020100, 16);
        send_run(8'h00, 16);
        idle(4);
        check("t5_sb_empty", WORD_W'(sb.size()), '0);
        check("t5_ovf", overflow_o, '0);

        // 6: asynchronous reset while a word is held
        rsa_ready_i = 1'b0;
        push(mk(8'h00, 16), 16);
        push(mk(8'h10, 16), 16);
        send_run(8'h00, 33);
        check("t6_pre_valid", rsa_valid_o, 1);
        check("t6_pre_ovf", overflow_o, 1);
        #1;
        rst = 1'b0;
        #1;
        check("t6_rst_valid", rsa_valid_o, '0);
        check("t6_rst_data", rsa_data_o, '0);
        check("t6_rst_ovf", overflow_o, '0);
`ifdef PS2_PACK_LEN_EN
        check("t6_rst_len", {{(WORD_W-IDX_W){1'b0}}, rsa_len_o}, '0);
`endif
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
        rsa_ready_i = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("t6_post_valid", rsa_valid_o, '0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
